// File: rtl/etx_pkg.sv
// Shared constants and types for the Ethernet TX test-payload generator:
// pattern encodings, header lengths, text ROM, PRBS taps and FSM states.
package etx_pkg;

    localparam logic [1:0] MODE_TEXT = 2'd0;
    localparam logic [1:0] MODE_CNT  = 2'd1;
    localparam logic [1:0] MODE_PRBS = 2'd2;

    localparam int UDP_HDR_LEN = 8;
    localparam int IP_HDR_LEN  = 20;

    // "Just for earthnet test!\r", first character in the most significant byte.
    localparam int TEXT_WORDS = 3;
    localparam logic [63:0] TEXT_ROM [TEXT_WORDS] = '{
        64'h4a757374_20666f72,
        64'h20656172_74686e65,
        64'h74207465_7374210d
    };

    localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;
    localparam logic [63:0] LFSR_SEED = 64'h1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_SEND,
        ST_GAP,
        ST_DONE
    } state_e;

endpackage

// File: rtl/etx_pattern_src.sv
// Payload word source: text ROM, packet/word counter or 64-bit Galois PRBS,
// selected by mode; only the active source advances on each written word.
module etx_pattern_src
    import etx_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int WCNT_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              advance_i,
    input  logic [1:0]        mode_i,
    input  logic [15:0]       pkt_cnt_i,
    input  logic [WCNT_W-1:0] widx_i,
    output logic [DATA_W-1:0] word_o
);

    logic [1:0]  rom_idx_q, rom_idx_d;
    logic [63:0] lfsr_q, lfsr_d;

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        word_o = DATA_W'(TEXT_ROM[rom_idx_q]);
        case (mode_i)
            MODE_CNT:  word_o = {pkt_cnt_i, (DATA_W-16)'(widx_i)};
            MODE_PRBS: word_o = DATA_W'(lfsr_q);
            default:   word_o = DATA_W'(TEXT_ROM[rom_idx_q]);
        endcase
    end

    always_comb begin
        rom_idx_d = rom_idx_q;
        lfsr_d    = lfsr_q;
        if (advance_i) begin
            case (mode_i)
                MODE_CNT:  ;
                MODE_PRBS: lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 64'h0);
                default:   rom_idx_d = (rom_idx_q == 2'(TEXT_WORDS - 1)) ? 2'd0 : rom_idx_q + 2'd1;
            endcase
        end
        // The ROM restarts with every run; the PRBS only reseeds on reset.
        if (clear_i) begin
            rom_idx_d = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so all
        // registers update together from the values before the edge.
        if (rst) begin
            rom_idx_q <= 2'd0;
            lfsr_q    <= LFSR_SEED;
        end else begin
            rom_idx_q <= rom_idx_d;
            lfsr_q    <= lfsr_d;
        end
    end

endmodule

// File: rtl/etx_test_gen.sv
// Ethernet TX test-payload generator: flushes the TX FIFO, then writes
// packets of programmable length and pattern with an idle gap between them.
module etx_test_gen
    import etx_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int MAX_WORDS = 256,
    parameter int WCNT_W    = 9,
    parameter int FLUSH_MAX = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [WCNT_W-1:0] cfg_words,
    input  logic [15:0]       cfg_gap,
    input  logic [15:0]       cfg_pkts,
    input  logic              etx_full,
    input  logic              etx_empty,
    output logic              ewr_en,
    output logic [DATA_W-1:0] etx_din,
    output logic              etx_enable,
    output logic [15:0]       tx_data_length,
    output logic [15:0]       tx_total_length,
    output logic              etx_fifo_rst,
    output logic              busy,
    output logic              done,
    output logic [15:0]       pkt_cnt
);

    localparam int FL_W = $clog2(FLUSH_MAX + 1);
    localparam logic [WCNT_W-1:0] MAX_W = WCNT_W'(MAX_WORDS);

    state_e             state_q, state_d;
    logic [WCNT_W-1:0]  words_q, words_d;
    logic [WCNT_W-1:0]  widx_q, widx_d;
    logic [15:0]        gap_cnt_q, gap_cnt_d;
    logic [FL_W-1:0]    flush_cnt_q, flush_cnt_d;
    logic [15:0]        pkt_cnt_q, pkt_cnt_d;
    logic               ewr_en_q, ewr_en_d;
    logic [DATA_W-1:0]  din_q, din_d;
    logic               fifo_rst_q, fifo_rst_d;
    logic [15:0]        data_len_q, data_len_d;
    logic [15:0]        total_len_q, total_len_d;

    logic               wr_ok, last_wr, flush_exit, pkt_start;
    logic               src_clear, src_advance;
    logic [15:0]        pkt_next;
    logic [WCNT_W-1:0]  eff_words;
    logic [DATA_W-1:0]  pattern_word;

    etx_pattern_src #(
        .DATA_W (DATA_W),
        .WCNT_W (WCNT_W)
    ) u_src (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (src_clear),
        .advance_i (src_advance),
        .mode_i    (mode),
        .pkt_cnt_i (pkt_cnt_q),
        .widx_i    (widx_q),
        .word_o    (pattern_word)
    );

    // Zero means one word; oversize requests clamp so the 16-bit lengths cannot wrap.
    always_comb begin
        eff_words = cfg_words;
        if (cfg_words == '0) begin
            eff_words = WCNT_W'(1);
        end else if (cfg_words > MAX_W) begin
            eff_words = MAX_W;
        end
    end

    assign wr_ok      = en && (state_q == ST_SEND) && !etx_full;
    assign last_wr    = wr_ok && (widx_q == words_q - WCNT_W'(1));
    assign pkt_next   = pkt_cnt_q + 16'd1;
    assign flush_exit = (state_q == ST_FLUSH) &&
                        (etx_empty || flush_cnt_q == FL_W'(FLUSH_MAX));

    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_FLUSH;
                ST_FLUSH: if (flush_exit) state_d = ST_SEND;
                ST_SEND: begin
                    if (last_wr) begin
                        if (cfg_pkts != 16'd0 && pkt_next == cfg_pkts) begin
                            state_d = ST_DONE;
                        end else if (cfg_gap != 16'd0) begin
                            state_d = ST_GAP;
                        end
                    end
                end
                ST_GAP:   if (gap_cnt_q <= 16'd1) state_d = ST_SEND;
                ST_DONE:  state_d = ST_DONE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // A packet starts on any entry to SEND, including a back-to-back restart.
    assign pkt_start = (state_d == ST_SEND) && ((state_q != ST_SEND) || last_wr);

    always_comb begin
        words_d     = words_q;
        widx_d      = widx_q;
        gap_cnt_d   = gap_cnt_q;
        flush_cnt_d = flush_cnt_q;
        pkt_cnt_d   = pkt_cnt_q;
        din_d       = din_q;
        data_len_d  = data_len_q;
        total_len_d = total_len_q;
        ewr_en_d    = 1'b0;
        fifo_rst_d  = 1'b0;
        src_clear   = 1'b0;
        src_advance = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    pkt_cnt_d   = 16'd0;
                    widx_d      = '0;
                    flush_cnt_d = '0;
                    src_clear   = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (en && !flush_exit) begin
                    fifo_rst_d  = 1'b1;
                    flush_cnt_d = flush_cnt_q + FL_W'(1);
                end
            end
            ST_SEND: begin
                if (wr_ok) begin
                    ewr_en_d    = 1'b1;
                    din_d       = pattern_word;
                    src_advance = 1'b1;
                    widx_d      = widx_q + WCNT_W'(1);
                    if (last_wr) begin
                        pkt_cnt_d = pkt_next;
                        gap_cnt_d = cfg_gap;
                    end
                end
            end
            ST_GAP:  gap_cnt_d = gap_cnt_q - 16'd1;
            default: ;
        endcase

        if (en && pkt_start) begin
            words_d     = eff_words;
            widx_d      = '0;
            data_len_d  = 16'(eff_words) * 16'd8 + 16'(UDP_HDR_LEN);
            total_len_d = data_len_d + 16'(IP_HDR_LEN);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            words_q     <= WCNT_W'(1);
            widx_q      <= '0;
            gap_cnt_q   <= 16'd0;
            flush_cnt_q <= '0;
            pkt_cnt_q   <= 16'd0;
            ewr_en_q    <= 1'b0;
            din_q       <= '0;
            fifo_rst_q  <= 1'b0;
            data_len_q  <= 16'd0;
            total_len_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            words_q     <= words_d;
            widx_q      <= widx_d;
            gap_cnt_q   <= gap_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            pkt_cnt_q   <= pkt_cnt_d;
            ewr_en_q    <= ewr_en_d;
            din_q       <= din_d;
            fifo_rst_q  <= fifo_rst_d;
            data_len_q  <= data_len_d;
            total_len_q <= total_len_d;
        end
    end

    assign ewr_en          = ewr_en_q;
    assign etx_din         = din_q;
    assign etx_enable      = 1'b1;
    assign tx_data_length  = data_len_q;
    assign tx_total_length = total_len_q;
    assign etx_fifo_rst    = fifo_rst_q;
    assign busy            = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done            = (state_q == ST_DONE);
    assign pkt_cnt         = pkt_cnt_q;

endmodule

// File: tb/tb_etx_test_gen.sv
// Directed bench for etx_test_gen: flush, patterns, backpressure, gaps,
// clamping and abort/reset, against hand-computed expected words.
module tb_etx_test_gen;

    logic        clk = 1'b0;
    logic        rst, en, etx_full, etx_empty;
    logic [1:0]  mode;
    logic [8:0]  cfg_words;
    logic [15:0] cfg_gap, cfg_pkts;
    logic        ewr_en, etx_enable, etx_fifo_rst, busy, done;
    logic [63:0] etx_din;
    logic [15:0] tx_data_length, tx_total_length, pkt_cnt;

    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          rst_hi = 0;
    int          last_rst_cyc = 0;
    logic [63:0] wr_q[$];
    int          wr_cyc[$];

    always #5 clk = ~clk;

    etx_test_gen dut (
        .clk             (clk),
        .rst             (rst),
        .en              (en),
        .mode            (mode),
        .cfg_words       (cfg_words),
        .cfg_gap         (cfg_gap),
        .cfg_pkts        (cfg_pkts),
        .etx_full        (etx_full),
        .etx_empty       (etx_empty),
        .ewr_en          (ewr_en),
        .etx_din         (etx_din),
        .etx_enable      (etx_enable),
        .tx_data_length  (tx_data_length),
        .tx_total_length (tx_total_length),
        .etx_fifo_rst    (etx_fifo_rst),
        .busy            (busy),
        .done            (done),
        .pkt_cnt         (pkt_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Every wait goes through here: sample on the falling edge and log writes/flush.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            cyc++;
            if (ewr_en) begin
                wr_q.push_back(etx_din);
                wr_cyc.push_back(cyc);
            end
            if (etx_fifo_rst) begin
                rst_hi++;
                last_rst_cyc = cyc;
            end
        end
    endtask

    function automatic logic [63:0] wr_at(input int i);
        return (i < wr_q.size()) ? wr_q[i] : 64'hx;
    endfunction

    function automatic logic [63:0] gap_at(input int i);
        return (i + 1 < wr_cyc.size()) ? 64'(wr_cyc[i+1] - wr_cyc[i]) : 64'hx;
    endfunction

    task automatic clear_log();
        wr_q.delete();
        wr_cyc.delete();
        rst_hi = 0;
        last_rst_cyc = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; etx_full = 1'b0; etx_empty = 1'b1;
        tick(2);
        rst = 1'b0;
        clear_log();
    endtask

    task automatic start(input logic [1:0] m, input logic [8:0] w,
                         input logic [15:0] g, input logic [15:0] p);
        mode = m; cfg_words = w; cfg_gap = g; cfg_pkts = p;
        en = 1'b1;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget && !done; i++) tick();
        if (!done) check({tag, " done timeout"}, 64'(done), 64'd1);
    endtask

    initial begin
        mode = 2'd0; cfg_words = 9'd1; cfg_gap = 16'd0; cfg_pkts = 16'd1;
        do_reset();

        // Reset state
        check("rst ewr_en", 64'(ewr_en), 64'd0);
        check("rst etx_din", etx_din, 64'd0);
        check("rst fifo_rst", 64'(etx_fifo_rst), 64'd0);
        check("rst busy/done", {62'd0, busy, done}, 64'd0);
        check("rst pkt_cnt", 64'(pkt_cnt), 64'd0);
        check("rst lengths", {32'd0, tx_data_length, tx_total_length}, 64'd0);
        check("etx_enable", 64'(etx_enable), 64'd1);

        // Single text packet
        start(2'd0, 9'd3, 16'd0, 16'd1);
        tick();
        check("flush busy", 64'(busy), 64'd1);
        wait_done("text", 50);
        check("text n", 64'(wr_q.size()), 64'd3);
        check("text w0", wr_at(0), 64'h4a757374_20666f72);
        check("text w1", wr_at(1), 64'h20656172_74686e65);
        check("text w2", wr_at(2), 64'h74207465_7374210d);
        check("text dlen", 64'(tx_data_length), 64'd32);
        check("text tlen", 64'(tx_total_length), 64'd52);
        check("text pkt_cnt", 64'(pkt_cnt), 64'd1);
        check("text busy", 64'(busy), 64'd0);
        en = 1'b0;
        tick();
        check("text done cleared", 64'(done), 64'd0);

        // Text ROM wraps across packet boundaries
        do_reset();
        start(2'd0, 9'd2, 16'd0, 16'd2);
        wait_done("wrap", 50);
        check("wrap w2", wr_at(2), 64'h74207465_7374210d);
        check("wrap w3", wr_at(3), 64'h4a757374_20666f72);

        // Mode 3 behaves as text
        do_reset();
        start(2'd3, 9'd1, 16'd0, 16'd1);
        wait_done("mode3", 50);
        check("mode3 w0", wr_at(0), 64'h4a757374_20666f72);

        // Flush for 5 cycles
        do_reset();
        etx_empty = 1'b0;
        start(2'd1, 9'd1, 16'd0, 16'd1);
        tick(6);
        etx_empty = 1'b1;
        wait_done("flush5", 50);
        check("flush5 rst cycles", 64'(rst_hi), 64'd5);
        check("flush5 first write", 64'(wr_cyc.size() > 0 ? wr_cyc[0] - last_rst_cyc : -1), 64'd2);

        // Flush timeout
        do_reset();
        etx_empty = 1'b0;
        start(2'd1, 9'd1, 16'd0, 16'd1);
        wait_done("flushto", 1100);
        check("flushto rst cycles", 64'(rst_hi), 64'd1023);
        check("flushto first write", 64'(wr_cyc.size() > 0 ? wr_cyc[0] - last_rst_cyc : -1), 64'd2);
        check("flushto n", 64'(wr_q.size()), 64'd1);
        etx_empty = 1'b1;

        // Backpressure: full held for three sampled edges after word 0
        do_reset();
        start(2'd1, 9'd4, 16'd0, 16'd1);
        tick(3);
        etx_full = 1'b1;
        tick(3);
        etx_full = 1'b0;
        wait_done("bp", 50);
        check("bp n", 64'(wr_q.size()), 64'd4);
        for (int i = 0; i < 4; i++) check($sformatf("bp w%0d", i), wr_at(i), 64'(i));
        check("bp stall", gap_at(0), 64'd4);
        check("bp resume", gap_at(1), 64'd1);

        // Three packets of two words with a 5-cycle gap
        do_reset();
        start(2'd1, 9'd2, 16'd5, 16'd3);
        wait_done("gap", 100);
        check("gap n", 64'(wr_q.size()), 64'd6);
        check("gap p1w1", wr_at(3), 64'h0001_0000_0000_0001);
        check("gap p2w0", wr_at(4), 64'h0002_0000_0000_0000);
        check("gap in-pkt", gap_at(0), 64'd1);
        check("gap 0-1", gap_at(1), 64'd6);
        check("gap 1-2", gap_at(3), 64'd6);
        check("gap pkt_cnt", 64'(pkt_cnt), 64'd3);
        check("gap dlen", 64'(tx_data_length), 64'd24);

        // PRBS with zero words -> one word per packet
        do_reset();
        start(2'd2, 9'd0, 16'd0, 16'd3);
        wait_done("prbs", 50);
        check("prbs w0", wr_at(0), 64'h1);
        check("prbs w1", wr_at(1), 64'hD800_0000_0000_0000);
        check("prbs w2", wr_at(2), 64'h6C00_0000_0000_0000);
        check("prbs dlen", 64'(tx_data_length), 64'd16);
        check("prbs tlen", 64'(tx_total_length), 64'd36);
        check("prbs b2b", gap_at(1), 64'd1);

        // Oversize word count clamps to 256
        do_reset();
        start(2'd1, 9'd300, 16'd0, 16'd1);
        wait_done("clamp", 400);
        check("clamp n", 64'(wr_q.size()), 64'd256);
        check("clamp last", wr_at(255), 64'h0000_0000_0000_00ff);
        check("clamp dlen", 64'(tx_data_length), 64'd2056);
        check("clamp tlen", 64'(tx_total_length), 64'd2076);

        // Abort after word 1 of 4
        do_reset();
        start(2'd1, 9'd4, 16'd0, 16'd0);
        tick(4);
        en = 1'b0;
        tick();
        check("abort ewr_en", 64'(ewr_en), 64'd0);
        check("abort busy/done", {62'd0, busy, done}, 64'd0);
        tick(2);
        check("abort n", 64'(wr_q.size()), 64'd2);

        // Synchronous reset mid-SEND, then PRBS reseeds
        do_reset();
        start(2'd2, 9'd1, 16'd0, 16'd0);
        tick(6);
        check("pre-rst pkt_cnt", 64'(pkt_cnt), 64'd4);
        rst = 1'b1;
        en = 1'b0;
        tick();
        check("mid rst ewr_en", 64'(ewr_en), 64'd0);
        check("mid rst etx_din", etx_din, 64'd0);
        check("mid rst pkt_cnt", 64'(pkt_cnt), 64'd0);
        check("mid rst lengths", {32'd0, tx_data_length, tx_total_length}, 64'd0);
        check("mid rst busy", 64'(busy), 64'd0);
        rst = 1'b0;
        tick();
        clear_log();
        start(2'd2, 9'd1, 16'd0, 16'd1);
        wait_done("reseed", 50);
        check("reseed w0", wr_at(0), 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
